// File: rtl/game_pkg.sv
// Shared types and default constants for the goal/score/match-clock logic.
package game_pkg;

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        GOAL_HOLD = 2'd1,
        SERVE     = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

    // Which goal mouth the ball currently occupies (left has priority).
    typedef enum logic [1:0] {
        SIDE_NONE = 2'd0,
        SIDE_L    = 2'd1,
        SIDE_R    = 2'd2
    } side_t;

    localparam logic [1:0] WINNER_NONE  = 2'b00;
    localparam logic [1:0] WINNER_LEFT  = 2'b01;
    localparam logic [1:0] WINNER_RIGHT = 2'b10;
    localparam logic [1:0] WINNER_TIE   = 2'b11;

    localparam logic [9:0] GOAL_L_X_MAX_DEF   = 10'd40;
    localparam logic [9:0] GOAL_R_X_MIN_DEF   = 10'd599;
    localparam logic [9:0] GOAL_Y_TOP_DEF     = 10'd300;
    localparam logic [7:0] HOLD_FRAMES_DEF    = 8'd120;
    localparam logic [3:0] WIN_SCORE_DEF      = 4'd5;
    localparam logic [6:0] MATCH_SECONDS_DEF  = 7'd90;
    localparam logic [5:0] FRAMES_PER_SEC_DEF = 6'd60;

    function automatic logic [1:0] winner_of(input logic [3:0] score_l, input logic [3:0] score_r);
        if (score_l > score_r)
            return WINNER_LEFT;
        else if (score_r > score_l)
            return WINNER_RIGHT;
        else
            return WINNER_TIE;
    endfunction

endpackage

// File: rtl/match_timer.sv
// Match clock: counts frames while enabled and steps the seconds countdown on each wrap.
module match_timer import game_pkg::*; #(
    parameter logic [6:0] MATCH_SECONDS  = MATCH_SECONDS_DEF,
    parameter logic [5:0] FRAMES_PER_SEC = FRAMES_PER_SEC_DEF
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       en,
    output logic [6:0] TimeLeft,
    output logic       expired
);

    logic [5:0] frame_cnt_reg;
    logic [6:0] time_left_reg;

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            frame_cnt_reg <= 6'd0;
            time_left_reg <= MATCH_SECONDS;
        end else if (en) begin
            if (frame_cnt_reg == FRAMES_PER_SEC - 6'd1) begin
                frame_cnt_reg <= 6'd0;
                // Hold at zero; the FSM leaves PLAY on the following edge.
                if (time_left_reg != 7'd0)
                    time_left_reg <= time_left_reg - 7'd1;
            end else begin
                frame_cnt_reg <= frame_cnt_reg + 6'd1;
            end
        end
    end

    assign TimeLeft = time_left_reg;
    assign expired  = (time_left_reg == 7'd0);

endmodule

// File: rtl/goal_scorer.sv
// Goal detection, scoring, post-goal freeze/re-serve sequencing and end-of-match decision.
module goal_scorer import game_pkg::*; #(
    parameter logic [9:0] GOAL_L_X_MAX   = GOAL_L_X_MAX_DEF,
    parameter logic [9:0] GOAL_R_X_MIN   = GOAL_R_X_MIN_DEF,
    parameter logic [9:0] GOAL_Y_TOP     = GOAL_Y_TOP_DEF,
    parameter logic [7:0] HOLD_FRAMES    = HOLD_FRAMES_DEF,
    parameter logic [3:0] WIN_SCORE      = WIN_SCORE_DEF,
    parameter logic [6:0] MATCH_SECONDS  = MATCH_SECONDS_DEF,
    parameter logic [5:0] FRAMES_PER_SEC = FRAMES_PER_SEC_DEF
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [9:0] BallX,
    input  logic [9:0] BallY,
    input  logic [9:0] BallS,
    output logic [3:0] ScoreL,
    output logic [3:0] ScoreR,
    output logic [6:0] TimeLeft,
    output logic       BallReset,
    output logic       GoalFlash,
    output logic       GameOver,
    output logic [1:0] Winner
);

    state_t     state_reg, state_next;
    side_t      pend_reg, pend_next, side_now;
    logic [7:0] hold_reg, hold_next;
    logic [3:0] score_l_reg, score_l_next;
    logic [3:0] score_r_reg, score_r_next;
    logic       ball_reset_reg, goal_flash_reg, game_over_reg;
    logic [1:0] winner_reg;
    logic       expired;
    logic       goal;

    logic [10:0] left_edge, right_edge, top_edge;
    logic        in_l, in_r;

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= WIN_SCORE) ? s : s + 4'd1;
    endfunction

    match_timer #(
        .MATCH_SECONDS (MATCH_SECONDS),
        .FRAMES_PER_SEC(FRAMES_PER_SEC)
    ) u_match_timer (
        .frame_clk(frame_clk),
        .Reset    (Reset),
        .en       (state_reg == PLAY),
        .TimeLeft (TimeLeft),
        .expired  (expired)
    );

    // Ball bounding box, widened so the right edge cannot wrap.
    always_comb begin
        left_edge  = (BallX >= BallS) ? ({1'b0, BallX} - {1'b0, BallS}) : 11'd0;
        right_edge = {1'b0, BallX} + {1'b0, BallS};
        top_edge   = (BallY >= BallS) ? ({1'b0, BallY} - {1'b0, BallS}) : 11'd0;
        in_l       = (left_edge <= {1'b0, GOAL_L_X_MAX}) && (top_edge >= {1'b0, GOAL_Y_TOP});
        in_r       = (right_edge >= {1'b0, GOAL_R_X_MIN}) && (top_edge >= {1'b0, GOAL_Y_TOP});
        side_now   = in_l ? SIDE_L : (in_r ? SIDE_R : SIDE_NONE);
        goal       = (side_now != SIDE_NONE) && (side_now == pend_reg);
    end

    always_comb begin
        state_next   = state_reg;
        pend_next    = pend_reg;
        hold_next    = hold_reg;
        score_l_next = score_l_reg;
        score_r_next = score_r_reg;
        case (state_reg)
            PLAY: begin
                if (expired) begin
                    state_next = GAME_OVER;
                end else if (goal) begin
                    // A ball in the left mouth is a goal for the right side.
                    if (side_now == SIDE_L)
                        score_r_next = sat_inc(score_r_reg);
                    else
                        score_l_next = sat_inc(score_l_reg);
                    hold_next  = HOLD_FRAMES - 8'd1;
                    pend_next  = SIDE_NONE;
                    state_next = GOAL_HOLD;
                end else begin
                    pend_next = side_now;
                end
            end
            GOAL_HOLD: begin
                if (hold_reg == 8'd0)
                    state_next = (score_l_reg == WIN_SCORE || score_r_reg == WIN_SCORE || expired)
                                 ? GAME_OVER : SERVE;
                else
                    hold_next = hold_reg - 8'd1;
            end
            SERVE: begin
                state_next = PLAY;
                pend_next  = SIDE_NONE;
            end
            GAME_OVER: begin
                state_next = GAME_OVER;
            end
            default: begin
                state_next = PLAY;
            end
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_reg      <= PLAY;
            pend_reg       <= SIDE_NONE;
            hold_reg       <= 8'd0;
            score_l_reg    <= 4'd0;
            score_r_reg    <= 4'd0;
            ball_reset_reg <= 1'b0;
            goal_flash_reg <= 1'b0;
            game_over_reg  <= 1'b0;
            winner_reg     <= WINNER_NONE;
        end else begin
            state_reg      <= state_next;
            pend_reg       <= pend_next;
            hold_reg       <= hold_next;
            score_l_reg    <= score_l_next;
            score_r_reg    <= score_r_next;
            // Outputs decode the next state so they line up with the state register.
            ball_reset_reg <= (state_next == SERVE);
            goal_flash_reg <= (state_next == GOAL_HOLD);
            game_over_reg  <= (state_next == GAME_OVER);
            winner_reg     <= (state_next == GAME_OVER) ? winner_of(score_l_next, score_r_next)
                                                         : WINNER_NONE;
        end
    end

    assign ScoreL    = score_l_reg;
    assign ScoreR    = score_r_reg;
    assign BallReset = ball_reset_reg;
    assign GoalFlash = goal_flash_reg;
    assign GameOver  = game_over_reg;
    assign Winner    = winner_reg;

endmodule

// File: tb/tb_goal_scorer.sv
// Self-checking bench for goal_scorer: directed table, hand sequences, and randomized play vs a model.
module tb_goal_scorer;

    localparam int HOLD = 120;
    localparam int WIN  = 5;
    localparam int FPS  = 60;
    localparam int SECS = 90;

    logic       frame_clk;
    logic       Reset;
    logic [9:0] BallX, BallY, BallS;
    logic [3:0] ScoreL, ScoreR;
    logic [6:0] TimeLeft;
    logic       BallReset, GoalFlash, GameOver;
    logic [1:0] Winner;

    // Second instance with a short match clock.
    logic       rst_t;
    logic [9:0] bx_t, by_t, bs_t;
    logic [3:0] ScoreL_t, ScoreR_t;
    logic [6:0] TimeLeft_t;
    logic       BallReset_t, GoalFlash_t, GameOver_t;
    logic [1:0] Winner_t;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    int  m_l, m_r, m_time, m_frame, m_flash, m_prev;
    bit  m_serve, m_over;

    goal_scorer dut (
        .frame_clk(frame_clk), .Reset(Reset),
        .BallX(BallX), .BallY(BallY), .BallS(BallS),
        .ScoreL(ScoreL), .ScoreR(ScoreR), .TimeLeft(TimeLeft),
        .BallReset(BallReset), .GoalFlash(GoalFlash),
        .GameOver(GameOver), .Winner(Winner)
    );

    goal_scorer #(.MATCH_SECONDS(7'd2)) dut_t (
        .frame_clk(frame_clk), .Reset(rst_t),
        .BallX(bx_t), .BallY(by_t), .BallS(bs_t),
        .ScoreL(ScoreL_t), .ScoreR(ScoreR_t), .TimeLeft(TimeLeft_t),
        .BallReset(BallReset_t), .GoalFlash(GoalFlash_t),
        .GameOver(GameOver_t), .Winner(Winner_t)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_l = 0; m_r = 0; m_time = SECS; m_frame = 0;
        m_flash = 0; m_prev = 0; m_serve = 0; m_over = 0;
    endtask

    // One frame of the game described in plain terms: 0 none, 1 left mouth, 2 right mouth.
    task automatic model_edge(input int bx, input int by, input int bs);
        int lft, rgt, top, side;
        lft = (bx - bs < 0) ? 0 : bx - bs;
        rgt = bx + bs;
        top = (by - bs < 0) ? 0 : by - bs;
        side = 0;
        if (lft <= 40 && top >= 300) side = 1;
        else if (rgt >= 599 && top >= 300) side = 2;
        if (m_over) begin
        end else if (m_serve) begin
            m_serve = 0; m_prev = 0;
        end else if (m_flash > 0) begin
            m_flash--;
            if (m_flash == 0) begin
                if (m_l == WIN || m_r == WIN || m_time == 0) m_over = 1;
                else m_serve = 1;
            end
        end else if (m_time == 0) begin
            m_over = 1;
        end else begin
            m_frame++;
            if (m_frame == FPS) begin m_frame = 0; m_time--; end
            if (side != 0 && side == m_prev) begin
                if (side == 1) m_r = (m_r + 1 > WIN) ? WIN : m_r + 1;
                else           m_l = (m_l + 1 > WIN) ? WIN : m_l + 1;
                m_flash = HOLD;
                m_prev = 0;
            end else begin
                m_prev = side;
            end
        end
    endtask

    task automatic cycle(input int bx, input int by, input int bs, input bit rst);
        int w;
        BallX = bx[9:0]; BallY = by[9:0]; BallS = bs[9:0]; Reset = rst;
        @(posedge frame_clk); #1;
        if (rst) model_reset(); else model_edge(bx, by, bs);
        w = !m_over ? 0 : (m_l > m_r) ? 1 : (m_r > m_l) ? 2 : 3;
        chk("m_ScoreL", ScoreL, m_l);
        chk("m_ScoreR", ScoreR, m_r);
        chk("m_TimeLeft", TimeLeft, m_time);
        chk("m_BallReset", BallReset, m_serve);
        chk("m_GoalFlash", GoalFlash, (m_flash > 0) ? 1 : 0);
        chk("m_GameOver", GameOver, m_over);
        chk("m_Winner", Winner, w);
    endtask

    typedef struct {
        bit rst;
        int bx, by, bs;
        int exp_l, exp_r;
        bit exp_flash;
    } vec_t;

    vec_t vecs[27];

    initial begin
        Reset = 1'b1; BallX = 10'd320; BallY = 10'd240; BallS = 10'd8;
        rst_t = 1'b1; bx_t = 10'd320; by_t = 10'd240; bs_t = 10'd8;
        model_reset();

        // Reset state
        cycle(320, 240, 8, 1);
        chk("rst_ScoreL", ScoreL, 0);     chk("rst_ScoreR", ScoreR, 0);
        chk("rst_TimeLeft", TimeLeft, 90); chk("rst_BallReset", BallReset, 0);
        chk("rst_GoalFlash", GoalFlash, 0); chk("rst_GameOver", GameOver, 0);
        chk("rst_Winner", Winner, 0);
        chk("t_rst_TimeLeft", TimeLeft_t, 2);
        $display("reset applied");

        // Two-second match with no goals
        rst_t = 1'b0;
        for (int k = 1; k <= 121; k++) begin
            cycle(320, 240, 8, 1);
            if (k == 60)  chk("t_time_60", TimeLeft_t, 1);
            if (k == 120) begin chk("t_time_120", TimeLeft_t, 0); chk("t_over_120", GameOver_t, 0); end
            if (k == 121) begin chk("t_over_121", GameOver_t, 1); chk("t_winner_121", Winner_t, 3); end
        end
        $display("short match expiry sequence done");

        // Goal counted on the edge the clock reaches zero
        rst_t = 1'b1; cycle(320, 240, 8, 1); rst_t = 1'b0;
        for (int k = 1; k <= 240; k++) begin
            if (k == 119 || k == 120) begin bx_t = 10'd30; by_t = 10'd400; bs_t = 10'd16; end
            else begin bx_t = 10'd320; by_t = 10'd240; bs_t = 10'd8; end
            cycle(320, 240, 8, 1);
            if (k == 120) begin
                chk("t_last_goal_R", ScoreR_t, 1); chk("t_last_flash", GoalFlash_t, 1);
                chk("t_last_time", TimeLeft_t, 0);
            end
            if (k == 239) begin chk("t_hold_over", GameOver_t, 0); chk("t_hold_flash", GoalFlash_t, 1); end
            if (k == 240) begin
                chk("t_end_over", GameOver_t, 1); chk("t_end_winner", Winner_t, 2);
                chk("t_end_flash", GoalFlash_t, 0); chk("t_end_serve", BallReset_t, 0);
            end
        end
        $display("goal at time expiry sequence done");

        // Directed table: {rst, x, y, s, ScoreL, ScoreR, GoalFlash}
        vecs[0]  = '{1, 320, 240, 16, 0, 0, 0};
        vecs[1]  = '{0,  30, 400, 16, 0, 0, 0};
        vecs[2]  = '{0, 320, 240, 16, 0, 0, 0};
        vecs[3]  = '{0,  30, 400, 16, 0, 0, 0};
        vecs[4]  = '{0,  30, 400, 16, 0, 1, 1};
        vecs[5]  = '{1, 320, 240, 16, 0, 0, 0};
        vecs[6]  = '{0, 610, 250, 16, 0, 0, 0};
        vecs[7]  = '{0, 610, 250, 16, 0, 0, 0};
        vecs[8]  = '{0, 610, 330, 16, 0, 0, 0};
        vecs[9]  = '{0, 610, 330, 16, 1, 0, 1};
        vecs[10] = '{1, 320, 240, 16, 0, 0, 0};
        vecs[11] = '{0,  56, 316, 16, 0, 0, 0};
        vecs[12] = '{0,  56, 316, 16, 0, 1, 1};
        vecs[13] = '{1, 320, 240, 16, 0, 0, 0};
        vecs[14] = '{0,  57, 316, 16, 0, 0, 0};
        vecs[15] = '{0,  57, 316, 16, 0, 0, 0};
        vecs[16] = '{0,  56, 315, 16, 0, 0, 0};
        vecs[17] = '{0,  56, 315, 16, 0, 0, 0};
        vecs[18] = '{0, 583, 316, 16, 0, 0, 0};
        vecs[19] = '{0, 583, 316, 16, 1, 0, 1};
        vecs[20] = '{1, 320, 240, 16, 0, 0, 0};
        vecs[21] = '{0, 320, 800, 400, 0, 0, 0};
        vecs[22] = '{0, 320, 800, 400, 0, 1, 1};
        vecs[23] = '{1, 320, 240, 16, 0, 0, 0};
        vecs[24] = '{0,  30, 400, 16, 0, 0, 0};
        vecs[25] = '{0, 610, 330, 16, 0, 0, 0};
        vecs[26] = '{0, 610, 330, 16, 1, 0, 1};
        for (int i = 0; i < 27; i++) begin
            cycle(vecs[i].bx, vecs[i].by, vecs[i].bs, vecs[i].rst);
            chk($sformatf("vec%0d_ScoreL", i), ScoreL, vecs[i].exp_l);
            chk($sformatf("vec%0d_ScoreR", i), ScoreR, vecs[i].exp_r);
            chk($sformatf("vec%0d_GoalFlash", i), GoalFlash, vecs[i].exp_flash);
            chk($sformatf("vec%0d_BallReset", i), BallReset, 0);
            $display("vec %0d: rst=%0d x=%0d y=%0d s=%0d -> L=%0d R=%0d flash=%0d",
                     i, vecs[i].rst, vecs[i].bx, vecs[i].by, vecs[i].bs, ScoreL, ScoreR, GoalFlash);
        end

        // Left goal, then the re-serve pulse exactly one hold later
        cycle(320, 240, 16, 1);
        cycle(30, 400, 16, 0);
        cycle(30, 400, 16, 0);
        chk("hold_ScoreR", ScoreR, 1); chk("hold_flash", GoalFlash, 1);
        for (int k = 1; k <= 121; k++) begin
            cycle(320, 240, 16, 0);
            chk($sformatf("hold_BallReset_%0d", k), BallReset, (k == 120) ? 1 : 0);
            chk($sformatf("hold_flash_%0d", k), GoalFlash, (k < 120) ? 1 : 0);
        end
        $display("hold and serve sequence done");

        // Five right-side goals end the match
        cycle(320, 240, 16, 1);
        for (int g = 1; g <= 5; g++) begin
            cycle(610, 330, 16, 0);
            cycle(610, 330, 16, 0);
            chk($sformatf("win_ScoreL_%0d", g), ScoreL, g);
            for (int k = 1; k <= 121; k++) begin
                cycle(320, 240, 16, 0);
                if (g == 5 && k == 120) begin
                    chk("win_GameOver", GameOver, 1); chk("win_Winner", Winner, 1);
                end
            end
            $display("goal %0d: ScoreL=%0d GameOver=%0d", g, ScoreL, GameOver);
        end
        for (int k = 0; k < 4; k++) cycle(30, 400, 16, 0);
        chk("frozen_ScoreL", ScoreL, 5); chk("frozen_ScoreR", ScoreR, 0);
        chk("frozen_GameOver", GameOver, 1);

        // Reset in the middle of a hold
        cycle(320, 240, 16, 1);
        cycle(30, 400, 16, 0);
        cycle(30, 400, 16, 0);
        for (int k = 0; k < 50; k++) cycle(320, 240, 16, 0);
        cycle(320, 240, 16, 1);
        chk("midhold_ScoreR", ScoreR, 0); chk("midhold_flash", GoalFlash, 0);
        chk("midhold_serve", BallReset, 0); chk("midhold_time", TimeLeft, 90);
        for (int k = 0; k < 130; k++) begin
            cycle(320, 240, 16, 0);
            chk("midhold_no_serve", BallReset, 0);
        end
        $display("reset during hold done");

        // Randomized play against the model
        cycle(320, 240, 16, 1);
        for (int b = 0; b < 700; b++) begin
            int mode, len, x, y, s;
            bit r;
            mode = $urandom_range(0, 9);
            len  = $urandom_range(1, 3);
            r    = 1'b0;
            s    = $urandom_range(0, 31);
            case (mode)
                0, 1, 2, 3: begin x = $urandom_range(100, 540); y = $urandom_range(0, 479); end
                4, 5:       begin x = $urandom_range(0, 60);    y = $urandom_range(280, 479); end
                6, 7:       begin x = $urandom_range(570, 639); y = $urandom_range(280, 479); end
                8:          begin x = $urandom_range(0, 1023);  y = $urandom_range(0, 1023);
                                  s = $urandom_range(0, 1023); end
                default:    begin x = 320; y = 240; r = ($urandom_range(0, 3) == 0); end
            endcase
            for (int k = 0; k < len; k++) cycle(x, y, s, r);
            $display("burst %0d: x=%0d y=%0d s=%0d rst=%0d len=%0d -> L=%0d R=%0d T=%0d over=%0d",
                     b, x, y, s, r, len, ScoreL, ScoreR, TimeLeft, GameOver);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
